// File: rtl/mem_pkg.sv
// Shared types and widths for the memory-access stage.
package mem_pkg;
    localparam int WORD_W  = 32;
    localparam int REG_W   = 5;
    localparam int LAT_MAX = 8;
    localparam int CNT_W   = $clog2(LAT_MAX);

    typedef enum logic {IDLE, BUSY} state_e;
endpackage

// File: rtl/data_mem.sv
// Single-port word RAM with write enable and a registered read port.
module data_mem
    import mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);
    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem_q[addr] <= wdata;
            else    rdata_q     <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution plus multi-cycle word loads/stores,
// stalling upstream while the data memory is busy.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int LAT   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_branch,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic [WORD_W-1:0] in_adder,
    input  logic              in_zf,
    input  logic [WORD_W-1:0] in_alu,
    input  logic [WORD_W-1:0] in_rd2,
    input  logic [REG_W-1:0]  in_mux5b,
    output logic              stall,
    output logic              pc_src,
    output logic [WORD_W-1:0] branch_target,
    output logic              addr_err,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic              wb_mem_to_reg,
    output logic [WORD_W-1:0] wb_read_data,
    output logic [WORD_W-1:0] wb_alu,
    output logic [REG_W-1:0]  wb_mux5b
);
    localparam int AW = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d, alu_q, alu_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic              wr_q, wr_d, regw_q, regw_d, m2r_q, m2r_d;

    logic              wb_valid_q, wb_valid_d, wb_regw_q, wb_regw_d;
    logic              wb_m2r_q, wb_m2r_d, wb_load_q, wb_load_d;
    logic [WORD_W-1:0] wb_alu_q, wb_alu_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic              err_q, err_d;

    logic              mem_op, err, ram_en;
    logic [WORD_W-1:0] ram_rdata;

    assign mem_op = in_valid & (in_mem_read | in_mem_write);
    assign err    = mem_op & ((in_alu[1:0] != 2'b00) | (in_alu >= WORD_W'(DEPTH * 4)));

    assign stall  = rst_n & (((state_q == IDLE) & mem_op & ~err) |
                             ((state_q == BUSY) & (cnt_q != '0)));
    assign pc_src = rst_n & in_valid & in_branch & in_zf & (state_q == IDLE);
    assign branch_target = in_adder;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        alu_d      = alu_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        regw_d     = regw_q;
        m2r_d      = m2r_q;
        wb_valid_d = 1'b0;
        wb_regw_d  = wb_regw_q;
        wb_m2r_d   = wb_m2r_q;
        wb_load_d  = wb_load_q;
        wb_alu_d   = wb_alu_q;
        wb_rd_d    = wb_rd_q;
        err_d      = 1'b0;
        ram_en     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_op && !err) begin
                    addr_d  = in_alu[AW+1:2];
                    wdata_d = in_rd2;
                    alu_d   = in_alu;
                    rd_d    = in_mux5b;
                    wr_d    = in_mem_write;
                    regw_d  = in_reg_write;
                    m2r_d   = in_mem_to_reg;
                    cnt_d   = CNT_W'(LAT - 1);
                    state_d = BUSY;
                end else if (in_valid) begin
                    // Faulting accesses retire here too, but never write a register.
                    wb_valid_d = 1'b1;
                    wb_regw_d  = in_reg_write & ~err;
                    wb_m2r_d   = in_mem_to_reg;
                    wb_load_d  = 1'b0;
                    wb_alu_d   = in_alu;
                    wb_rd_d    = in_mux5b;
                    err_d      = err;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    ram_en     = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_regw_d  = regw_q;
                    wb_m2r_d   = m2r_q;
                    wb_load_d  = ~wr_q;
                    wb_alu_d   = alu_q;
                    wb_rd_d    = rd_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_regw_q  <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_load_q  <= 1'b0;
            wb_alu_q   <= '0;
            wb_rd_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_regw_q  <= wb_regw_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_load_q  <= wb_load_d;
            wb_alu_q   <= wb_alu_d;
            wb_rd_q    <= wb_rd_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        alu_q   <= alu_d;
        rd_q    <= rd_d;
        wr_q    <= wr_d;
        regw_q  <= regw_d;
        m2r_q   <= m2r_d;
    end

    // Gating with rst_n keeps a reset landing on the final BUSY edge from writing.
    data_mem #(.DEPTH(DEPTH)) u_dmem (
        .clk   (clk),
        .en    (ram_en & rst_n),
        .we    (wr_q),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_regw_q;
    assign wb_mem_to_reg = wb_m2r_q;
    assign wb_read_data  = wb_load_q ? ram_rdata : '0;
    assign wb_alu        = wb_alu_q;
    assign wb_mux5b      = wb_rd_q;
    assign addr_err      = err_q;
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the pipelined datapath, directly downstream of the EX/MEM pipeline buffer. It consumes the buffered ALU result, store data, branch target, zero flag and destination register. It resolves the branch decision and performs word loads and stores against an internal data memory with a configurable multi-cycle latency, stalling upstream while busy. It presents registered results to the write-back stage.

## Interface
- `DEPTH`, 64: data memory size in 32-bit words; power of two.
- `LAT`, 2: memory access latency in cycles; legal range 1..8.

- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: EX/MEM slot holds a live instruction.
- `in_mem_read` in 1: load word.
- `in_mem_write` in 1: store word.
- `in_branch` in 1: conditional branch (beq).
- `in_reg_write` in 1: instruction writes the register file.
- `in_mem_to_reg` in 1: write-back selects load data.
- `in_adder` in 32: branch target.
- `in_zf` in 1: ALU zero flag.
- `in_alu` in 32: ALU result, the byte address for loads and stores.
- `in_rd2` in 32: store data.
- `in_mux5b` in 5: destination register.
- `stall` out 1: hold EX/MEM and all earlier stages.
- `pc_src` out 1: take branch.
- `branch_target` out 32: next PC when `pc_src` is high.
- `addr_err` out 1: one-cycle pulse on a misaligned or out-of-range access.
- `wb_valid`, `wb_reg_write`, `wb_mem_to_reg` out 1 each: MEM/WB control.
- `wb_read_data` out 32: load result.
- `wb_alu` out 32: ALU result passed through.
- `wb_mux5b` out 5: destination register.

## Operation
- Memory operation: `mem_op = in_valid & (in_mem_read | in_mem_write)`. Read and write are never both set.
- Address error:
  - Condition: `mem_op & (in_alu[1:0] != 0 | in_alu >= DEPTH*4)`.
  - Response: no access, no stall, `addr_err` = 1 at the next posedge, `wb_reg_write` forced to 0.
- Word index is `in_alu[log2(DEPTH)+1:2]`.
- Branch logic is combinational: `pc_src = in_valid & in_branch & in_zf & (state == IDLE)`, and `branch_target = in_adder`.
- FSM states are IDLE and BUSY.
  - IDLE with `mem_op` and no error: capture address, data, read/write flag, `in_mux5b`, `in_reg_write` and `in_mem_to_reg`; load `cnt = LAT-1`; go to BUSY.
  - IDLE with a non-memory instruction (or an error): register the pass-through fields into `wb_*` at the next posedge; `wb_read_data` = 0; stay in IDLE.
  - IDLE with `in_valid` = 0: `wb_valid` = 0 next cycle.
  - BUSY with `cnt != 0`: decrement `cnt`; `wb_valid` = 0.
  - BUSY with `cnt == 0`: perform the access at this posedge (store writes memory; load registers `wb_read_data`), drive all `wb_*` from the captured fields with `wb_valid` = 1, return to IDLE.
- Stall is combinational: `stall = (IDLE & mem_op & ~err) | (BUSY & cnt != 0)`. It deasserts in the final BUSY cycle so upstream advances on the same edge the access completes.
- Inputs are not re-sampled while in BUSY; upstream holds them because `stall` is high.

## Timing
- Reset (`rst_n` = 0 at posedge) sets the state to IDLE, `cnt` to 0, and every `wb_*` output and `addr_err` to 0.
  - `stall` and `pc_src` are 0 while in reset.
  - Memory contents are not reset.
- Reset asserted during BUSY aborts the access; no memory write occurs.
- Non-memory instruction: 1 cycle to `wb_*`, no stall.
- Memory instruction: `stall` is high for exactly LAT cycles. The result appears in `wb_*` LAT+1 posedges after acceptance, with `wb_valid` high for 1 cycle.
- With LAT = 1: stall high for the accept cycle only; the result appears 2 posedges after acceptance.
- Back-to-back memory instructions: the second is accepted in the cycle after the first returns to IDLE, with no gap beyond the stall.

## Structure
- Shared package `mem_pkg`:
  - state enum (IDLE, BUSY)
  - `WORD_W` = 32, `REG_W` = 5
  - `LAT_MAX` = 8
- Sub-module `data_mem`: synchronous single-port RAM, DEPTH x 32, with write enable and a registered read. It is instantiated once. The FSM drives its enable on the final BUSY cycle.

## Test plan
- Reset: hold `rst_n` = 0 for 2 cycles with random inputs → all outputs 0, `stall` = 0.
- Store then load, LAT = 2:
  - sw with `in_alu` = 0x10, `in_rd2` = 0xDEADBEEF → `stall` high for 2 cycles.
  - Then lw from 0x10 with `in_mux5b` = 8 → `wb_read_data` = 0xDEADBEEF, `wb_mux5b` = 8, `wb_mem_to_reg` = 1, `wb_valid` pulse 3 posedges after acceptance.
- Branch:
  - `in_branch` = 1, `in_zf` = 1, `in_adder` = 0x40 → `pc_src` = 1 and `branch_target` = 0x40 in the same cycle.
  - With `in_zf` = 0 → `pc_src` = 0.
- Address errors:
  - lw at 0x13 → `addr_err` pulses once, no stall, `wb_reg_write` = 0.
  - sw at `DEPTH*4` → `addr_err` pulses and memory is unchanged (verified by a later read of word 0 and word DEPTH-1).
- Reset mid-operation: sw of 0x1234 to 0x20, with `rst_n` dropped in the first BUSY cycle → a later lw from 0x20 returns the prior value.
- R-type pass-through: `in_alu` = 0x55, `in_reg_write` = 1, `in_mux5b` = 3 → the next cycle shows `wb_alu` = 0x55, `wb_mux5b` = 3, `wb_valid` = 1, `stall` never asserted.
